// File: rtl/uart_word_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_tx
// Description : 8N1 UART transmitter that sends a latched 32-bit word as
//               NUM_BYTES consecutive frames, least-significant byte first,
//               with no idle gap between the frames of one word.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_word_tx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int NUM_BYTES    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        valid,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic        tx
);

    localparam int                  c_baud_w    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_baud_w-1:0] c_baud_max  = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [1:0]          c_last_byte = 2'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t              r_state, w_state_next;
    logic [c_baud_w-1:0] r_baud,  w_baud_next;
    logic [2:0]          r_bit,   w_bit_next;
    logic [1:0]          r_byte,  w_byte_next;
    logic [31:0]         r_shift, w_shift_next;
    logic                r_tx,    w_tx_next;
    logic                r_ready, w_ready_next;
    logic                r_busy,  w_busy_next;
    logic                r_done,  w_done_next;

    // The byte currently on the line always sits in the low 8 bits of the shifter
    logic [7:0]          w_cur_byte;
    logic [2:0]          w_bit_inc;

    assign w_cur_byte = r_shift[7:0];
    assign w_bit_inc  = r_bit + 3'd1;

    // State and output registers; reset forces the line high and drops any word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_byte  <= w_byte_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
            r_ready <= w_ready_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    // Next-state logic; tx only moves at a baud wrap or on acceptance
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_byte_next  = r_byte;
        w_shift_next = r_shift;
        w_tx_next    = r_tx;
        w_ready_next = r_ready;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;

        if (r_state == ST_IDLE) begin
            // ready is high throughout IDLE, so valid alone means acceptance
            if (valid) begin
                w_shift_next = data_in;
                w_state_next = ST_START;
                w_baud_next  = '0;
                w_bit_next   = '0;
                w_byte_next  = '0;
                w_tx_next    = 1'b0;
                w_ready_next = 1'b0;
                w_busy_next  = 1'b1;
            end
        end else if (r_baud != c_baud_max) begin
            w_baud_next = r_baud + 1'b1;
        end else begin
            w_baud_next = '0;
            case (r_state)
                ST_START: begin
                    w_state_next = ST_DATA;
                    w_bit_next   = '0;
                    w_tx_next    = w_cur_byte[0];
                end
                ST_DATA: begin
                    if (r_bit == 3'd7) begin
                        w_state_next = ST_STOP;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_bit_next = w_bit_inc;
                        w_tx_next  = w_cur_byte[w_bit_inc];
                    end
                end
                ST_STOP: begin
                    if (r_byte == c_last_byte) begin
                        w_state_next = ST_IDLE;
                        w_tx_next    = 1'b1;
                        w_ready_next = 1'b1;
                        w_busy_next  = 1'b0;
                        w_done_next  = 1'b1;
                    end else begin
                        // Next byte's start bit follows the stop bit directly
                        w_byte_next  = r_byte + 2'd1;
                        w_shift_next = r_shift >> 8;
                        w_state_next = ST_START;
                        w_tx_next    = 1'b0;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_tx_next    = 1'b1;
                    w_ready_next = 1'b1;
                    w_busy_next  = 1'b0;
                end
            endcase
        end
    end

    assign tx    = r_tx;
    assign ready = r_ready;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_word_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_word_tx
// Description : Directed self-checking bench for uart_word_tx. A 4-byte and a
//               1-byte instance share clock, reset and data; sel picks which
//               one receives valid and which one is monitored.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_word_tx;

    localparam int C_CLKS = 4;

    logic        clk;
    logic        rst;
    logic [31:0] data_in;
    logic        valid;
    logic        sel;

    logic        w_valid0, w_valid1;
    logic        w_ready0, w_busy0, w_done0, w_tx0;
    logic        w_ready1, w_busy1, w_done1, w_tx1;
    logic        w_mon_ready, w_mon_busy, w_mon_done, w_mon_tx;

    int          n_checks;
    int          n_pass;

    assign w_valid0    = valid & ~sel;
    assign w_valid1    = valid & sel;
    assign w_mon_ready = sel ? w_ready1 : w_ready0;
    assign w_mon_busy  = sel ? w_busy1  : w_busy0;
    assign w_mon_done  = sel ? w_done1  : w_done0;
    assign w_mon_tx    = sel ? w_tx1    : w_tx0;

    uart_word_tx #(.CLKS_PER_BIT(C_CLKS), .NUM_BYTES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .valid   (w_valid0),
        .ready   (w_ready0),
        .busy    (w_busy0),
        .done    (w_done0),
        .tx      (w_tx0)
    );

    uart_word_tx #(.CLKS_PER_BIT(C_CLKS), .NUM_BYTES(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .valid   (w_valid1),
        .ready   (w_ready1),
        .busy    (w_busy1),
        .done    (w_done1),
        .tx      (w_tx1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected line level i cycles into the frame sequence (i=0 is the first start-bit cycle)
    function automatic logic exp_tx(input logic [31:0] word, input int i);
        int bp;
        int b;
        bp = (i / C_CLKS) % 10;
        b  = i / (10 * C_CLKS);
        if (bp == 0) return 1'b0;
        if (bp == 9) return 1'b1;
        return word[b*8 + bp - 1];
    endfunction

    // Present a word and pass the acceptance edge; leaves the bench at cycle 1 of the frame
    task automatic start_word(input logic s, input logic [31:0] word, input logic hold);
        sel     = s;
        data_in = word;
        valid   = 1'b1;
        step();
        if (!hold) valid = 1'b0;
    endtask

    // Capture one whole word, compare against the model, then check the done cycle.
    // inj_at >= 0 pulses a stray valid with all-ones data at that frame cycle.
    task automatic capture_word(input string tag, input logic [31:0] word, input int nb, input int inj_at);
        logic samp [0:159];
        int   n;
        int   e_tx;
        int   e_hs;
        logic [7:0] got;
        n    = 10 * nb * C_CLKS;
        e_tx = 0;
        e_hs = 0;
        for (int i = 0; i < n; i++) begin
            if (i == inj_at) begin
                valid   = 1'b1;
                data_in = 32'hFFFF_FFFF;
            end else if (inj_at >= 0 && i == inj_at + 1) begin
                valid   = 1'b0;
                data_in = 32'h0;
            end
            samp[i] = w_mon_tx;
            if (w_mon_tx !== exp_tx(word, i)) e_tx++;
            if (w_mon_ready !== 1'b0 || w_mon_busy !== 1'b1 || w_mon_done !== 1'b0) e_hs++;
            step();
        end
        check({tag, " tx_level_errs"}, e_tx, 0);
        check({tag, " handshake_errs"}, e_hs, 0);
        for (int k = 0; k < nb; k++) begin
            for (int j = 0; j < 8; j++) got[j] = samp[k*40 + (j+1)*C_CLKS + 2];
            check($sformatf("%s byte%0d", tag, k), {24'h0, got}, {24'h0, word[k*8 +: 8]});
        end
        check({tag, " done"},  {31'h0, w_mon_done},  32'h1);
        check({tag, " ready"}, {31'h0, w_mon_ready}, 32'h1);
        check({tag, " busy"},  {31'h0, w_mon_busy},  32'h0);
        check({tag, " tx_idle"}, {31'h0, w_mon_tx},  32'h1);
    endtask

    initial begin
        int e;
        n_checks = 0;
        n_pass   = 0;
        sel      = 1'b0;
        valid    = 1'b0;
        data_in  = 32'h0;
        rst      = 1'b0;
        #1 rst   = 1'b1;

        // Reset and idle
        #2;
        check("rst tx",    {31'h0, w_tx0},    32'h1);
        check("rst ready", {31'h0, w_ready0}, 32'h1);
        check("rst busy",  {31'h0, w_busy0},  32'h0);
        check("rst done",  {31'h0, w_done0},  32'h0);
        step();
        step();
        rst = 1'b0;
        e = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (w_tx0 !== 1'b1 || w_ready0 !== 1'b1 || w_done0 !== 1'b0) e++;
        end
        check("idle 50 cycles", e, 0);

        // Single word, four bytes
        start_word(1'b0, 32'h1234_5678, 1'b0);
        capture_word("word1", 32'h1234_5678, 4, -1);
        step();
        check("word1 done one-shot", {31'h0, w_done0}, 32'h0);

        // Bit timing on the one-byte instance
        step();
        start_word(1'b1, 32'h0000_0055, 1'b0);
        capture_word("bits55", 32'h0000_0055, 1, -1);
        step();
        sel = 1'b0;

        // Stray request mid-frame must be dropped
        step();
        start_word(1'b0, 32'h0000_0000, 1'b0);
        capture_word("ignore", 32'h0000_0000, 4, 50);
        e = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (w_tx0 !== 1'b1 || w_ready0 !== 1'b1 || w_done0 !== 1'b0) e++;
        end
        check("ignore no queued frame", e, 0);

        // Back-to-back with valid held high
        start_word(1'b0, 32'hA5A5_A5A5, 1'b1);
        capture_word("b2b first", 32'hA5A5_A5A5, 4, -1);
        step();
        valid = 1'b0;
        check("b2b restart ready", {31'h0, w_ready0}, 32'h0);
        capture_word("b2b second", 32'hA5A5_A5A5, 4, -1);
        step();
        check("b2b done one-shot", {31'h0, w_done0}, 32'h0);

        // Asynchronous reset during the second byte's data bits
        start_word(1'b0, 32'h1234_5678, 1'b0);
        for (int i = 0; i < 60; i++) step();
        #3 rst = 1'b1;
        #1;
        check("arst tx",    {31'h0, w_tx0},    32'h1);
        check("arst ready", {31'h0, w_ready0}, 32'h1);
        check("arst busy",  {31'h0, w_busy0},  32'h0);
        @(posedge clk);
        @(posedge clk);
        #4 rst = 1'b0;
        e = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (w_tx0 !== 1'b1 || w_ready0 !== 1'b1 || w_done0 !== 1'b0) e++;
        end
        check("arst no residual", e, 0);
        start_word(1'b0, 32'h0000_00C3, 1'b0);
        capture_word("after rst", 32'h0000_00C3, 4, -1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
